// File: rtl/mmio_bus_arb_if.sv
// MMIO register bus between mmio_bus_arb (master) and the mmio peripheral block (slave).
interface mmio_bus_arb_if;
    logic        m_re;
    logic        m_we;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        m_stall;
    logic        m_ack;

    modport master (
        output m_re, m_we, m_addr, m_wdata,
        input  m_rdata, m_stall, m_ack
    );

    modport slave (
        input  m_re, m_we, m_addr, m_wdata,
        output m_rdata, m_stall, m_ack
    );
endinterface

// File: rtl/mmio_bus_arb.sv
// Round-robin two-port arbiter and re/we sequencer in front of mmio.
// Optional access timeout enabled by defining MMIO_ARB_TIMEOUT_EN.
module mmio_bus_arb #(
    parameter logic [15:0] ACK_MASK = 16'h0018,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    mmio_bus_arb_if.master mbus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIXED,
        S_CAPTURE,
        S_DONE
    } state_t;

    if (TIMEOUT < 2) begin : g_timeout_min
        $error("mmio_bus_arb: TIMEOUT must be at least 2");
    end

    state_t      state_q, state_d;
    logic        m_re_q, m_re_d;
    logic        m_we_q, m_we_d;
    logic [11:0] m_addr_q, m_addr_d;
    logic [7:0]  m_wdata_q, m_wdata_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        we_q, we_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        ack_mode_q, ack_mode_d;

    // Winner of the IDLE-cycle arbitration: 1 selects port 1.
    logic        win;
    logic        win_we;
    logic [11:0] win_addr;
    logic [7:0]  win_wdata;

    assign win       = (req0 && req1) ? ~last_grant_q : req1;
    assign win_we    = win ? we1    : we0;
    assign win_addr  = win ? addr1  : addr0;
    assign win_wdata = win ? wdata1 : wdata0;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        m_re_d       = m_re_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        we_d         = we_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack_mode_d   = ack_mode_q;
`ifdef MMIO_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d    = win;
                    we_d       = win_we;
                    m_addr_d   = win_addr;
                    m_wdata_d  = win_wdata;
                    m_re_d     = ~win_we;
                    m_we_d     = win_we;
                    ack_mode_d = ACK_MASK[win_addr[11:8]];
`ifdef MMIO_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mbus.m_stall) begin
                    if (ack_mode_q) begin
                        state_d = S_WAIT;
                    end else begin
                        m_re_d  = 1'b0;
                        m_we_d  = 1'b0;
                        state_d = S_FIXED;
                    end
                end
            end
            S_WAIT: begin
                // Ack completions reuse FIXED as the data-settle cycle, so done
                // lands three cycles after the ack just as after a fixed strobe.
                if (mbus.m_ack && !mbus.m_stall) begin
                    m_re_d  = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = S_FIXED;
                end
            end
            S_FIXED: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!we_q) begin
                    if (grant_q) rdata1_d = mbus.m_rdata;
                    else         rdata0_d = mbus.m_rdata;
                end
                if (grant_q) done1_d = 1'b1;
                else         done0_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MMIO_ARB_TIMEOUT_EN
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TO_LAST) begin
                m_re_d  = 1'b0;
                m_we_d  = 1'b0;
                if (!we_q) begin
                    if (grant_q) rdata1_d = 8'hFF;
                    else         rdata0_d = 8'hFF;
                end
                if (grant_q) done1_d = 1'b1;
                else         done0_d = 1'b1;
                err_d   = 1'b1;
                state_d = S_DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            m_re_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            we_q         <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack_mode_q   <= 1'b0;
`ifdef MMIO_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            m_re_q       <= m_re_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            we_q         <= we_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack_mode_q   <= ack_mode_d;
`ifdef MMIO_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign mbus.m_re    = m_re_q;
    assign mbus.m_we    = m_we_q;
    assign mbus.m_addr  = m_addr_q;
    assign mbus.m_wdata = m_wdata_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;

`ifdef MMIO_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bus_arb.sv
// Directed bench for mmio_bus_arb; cycle numbers count from the IDLE cycle that sees the request.
module tb_mmio_bus_arb;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  rdata0, rdata1;
    logic        done0, done1, err;

    int compared = 0;
    int mism     = 0;

    mmio_bus_arb_if mbus ();

    mmio_bus_arb #(
        .ACK_MASK (16'h0018),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .done0  (done0),
        .done1  (done1),
        .err    (err),
        .mbus   (mbus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mbus.m_rdata = '0; mbus.m_stall = 1'b0; mbus.m_ack = 1'b0;
        step();
        step();
        chk("rst_m_re", mbus.m_re, 0);
        chk("rst_m_we", mbus.m_we, 0);
        chk("rst_m_addr", mbus.m_addr, 0);
        chk("rst_m_wdata", mbus.m_wdata, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        rst = 1'b0;

        // Port 0 fixed-latency read of 0x005
        we0 = 1'b0; addr0 = 12'h005; req0 = 1'b1;
        step();
        chk("t1_c1_m_re", mbus.m_re, 1);
        chk("t1_c1_m_we", mbus.m_we, 0);
        chk("t1_c1_m_addr", mbus.m_addr, 12'h005);
        step();
        chk("t1_c2_m_re", mbus.m_re, 0);
        mbus.m_rdata = 8'hA5;
        step();
        chk("t1_c3_done0", done0, 0);
        step();
        chk("t1_c4_done0", done0, 1);
        chk("t1_c4_done1", done1, 0);
        chk("t1_c4_rdata0", rdata0, 8'hA5);
        chk("t1_c4_rdata1", rdata1, 0);
        req0 = 1'b0;
        step();
        chk("t1_c5_done0", done0, 0);
        chk("t1_c5_rdata0_held", rdata0, 8'hA5);

        // Reset while waiting on a ps2 read of 0x400
        addr0 = 12'h400; req0 = 1'b1; mbus.m_rdata = 8'h3C;
        step();
        chk("t4_c1_m_re", mbus.m_re, 1);
        step();
        chk("t4_c2_m_re_wait", mbus.m_re, 1);
        rst = 1'b1; req0 = 1'b0;
        step();
        chk("t4_rst_m_re", mbus.m_re, 0);
        chk("t4_rst_m_we", mbus.m_we, 0);
        chk("t4_rst_done0", done0, 0);
        chk("t4_rst_rdata0", rdata0, 0);
        chk("t4_rst_m_addr", mbus.m_addr, 0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done0) n++;
        end
        chk("t4_no_done0", n, 0);
        chk("t4_idle_m_re", mbus.m_re, 0);

        // Contending writes; port 0 first after reset, then alternation
        we0 = 1'b1; addr0 = 12'h010; wdata0 = 8'h11;
        we1 = 1'b1; addr1 = 12'h011; wdata1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("t2_c1_m_we", mbus.m_we, 1);
        chk("t2_c1_m_re", mbus.m_re, 0);
        chk("t2_c1_m_addr", mbus.m_addr, 12'h010);
        chk("t2_c1_m_wdata", mbus.m_wdata, 8'h11);
        step();
        chk("t2_c2_m_we", mbus.m_we, 0);
        step();
        step();
        chk("t2_c4_done0", done0, 1);
        chk("t2_c4_done1", done1, 0);
        step();
        chk("t2_c5_idle_m_we", mbus.m_we, 0);
        chk("t2_c5_done0", done0, 0);
        step();
        chk("t2_c6_m_we", mbus.m_we, 1);
        chk("t2_c6_m_addr", mbus.m_addr, 12'h011);
        chk("t2_c6_m_wdata", mbus.m_wdata, 8'h22);
        step();
        chk("t2_c7_m_we", mbus.m_we, 0);
        step();
        step();
        chk("t2_c9_done1", done1, 1);
        chk("t2_c9_done0", done0, 0);
        chk("t2_c9_rdata0", rdata0, 0);
        chk("t2_c9_rdata1", rdata1, 0);
        req1 = 1'b0;
        step();
        step();
        chk("t2_c11_m_we", mbus.m_we, 1);
        chk("t2_c11_m_addr", mbus.m_addr, 12'h010);
        step();
        step();
        step();
        chk("t2_c14_done0", done0, 1);
        req0 = 1'b0;
        step();

        // Port 1 ack-mode write to 0x302 with three stall cycles
        we1 = 1'b1; addr1 = 12'h302; wdata1 = 8'h5A; req1 = 1'b1; mbus.m_stall = 1'b1;
        n = 0;
        step();
        chk("t3_c1_m_we", mbus.m_we, 1);
        chk("t3_c1_m_addr", mbus.m_addr, 12'h302);
        step();
        chk("t3_c2_m_we", mbus.m_we, 1);
        step();
        chk("t3_c3_m_we", mbus.m_we, 1);
        step();
        mbus.m_stall = 1'b0;
        chk("t3_c4_m_we", mbus.m_we, 1);
        step();
        chk("t3_c5_m_we", mbus.m_we, 1);
        step();
        chk("t3_c6_m_we", mbus.m_we, 1);
        mbus.m_ack = 1'b1;
        step();
        mbus.m_ack = 1'b0;
        chk("t3_c7_m_we", mbus.m_we, 0);
        if (done1) n++;
        step();
        chk("t3_c8_done1", done1, 0);
        if (done1) n++;
        step();
        chk("t3_c9_done1", done1, 1);
        chk("t3_c9_rdata1", rdata1, 0);
        if (done1) n++;
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done1) n++;
        end
        chk("t3_done1_count", n, 1);

        // Ack-mode read of 0x300 that never sees m_ack
        we0 = 1'b0; addr0 = 12'h300; req0 = 1'b1;
`ifdef MMIO_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mbus.m_re) n++;
        end
        chk("t5_strobe_cycles", n, 8);
        step();
        chk("t5_c9_m_re", mbus.m_re, 0);
        chk("t5_c9_done0", done0, 1);
        chk("t5_c9_err", err, 1);
        chk("t5_c9_rdata0", rdata0, 8'hFF);
        req0 = 1'b0;
        step();
        chk("t5_c10_done0", done0, 0);
        chk("t5_c10_err", err, 0);
`else
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (done0 || err) n++;
        end
        chk("t5_no_completion", n, 0);
        chk("t5_m_re_held", mbus.m_re, 1);
        rst = 1'b1; req0 = 1'b0;
        step();
        rst = 1'b0;
        chk("t5_after_rst_m_re", mbus.m_re, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
